// File: rtl/fp_div_seq.sv
// fp_div_seq: sequential IEEE-754 single-precision divider (a / b).
// Radix-2 restoring division, one quotient bit per clock, start/done handshake.
// Fixed latency: done is high in the cycle after the 28th edge following acceptance.
// Optional build macro FP_DIV_ROUND_EN: round-to-nearest-even; otherwise truncation.
module fp_div_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [EXP_W+MAN_W:0]   a_operand,
  input  logic [EXP_W+MAN_W:0]   b_operand,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   Exception,
  output logic                   Overflow,
  output logic                   Underflow
);

  localparam int W    = EXP_W + MAN_W + 1;
  localparam int QB   = MAN_W + 3;
  localparam int SW   = EXP_W + 2;
  localparam int CW   = $clog2(QB);
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;

  localparam logic [EXP_W-1:0]     C_E_ONES   = '1;
  localparam logic signed [SW-1:0] C_EXP_MAX  = SW'(EMAX);
  localparam logic signed [SW-1:0] C_EXP_ZERO = '0;
  localparam logic [SW-1:0]        C_BIAS     = SW'(BIAS);
  localparam logic [W-1:0]         C_QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_UNPACK, S_DIV, S_NORM} state_t;

  state_t                r_state;
  logic [W-1:0]          r_a;
  logic [W-1:0]          r_b;
  logic                  r_sign;
  logic signed [SW-1:0]  r_exp;
  logic [MAN_W:0]        r_mb;
  logic [MAN_W+1:0]      r_rem;
  logic [QB-1:0]         r_q;
  logic [CW-1:0]         r_cnt;
  logic                  r_nan;
  logic                  r_inf_div;
  logic                  r_zero;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_exc;
  logic                  r_ovf;
  logic                  r_unf;
  logic [W-1:0]          r_result;

  // Operand classification from the latched operands
  logic [EXP_W-1:0] w_ea;
  logic [EXP_W-1:0] w_eb;
  logic             w_a_zero;
  logic             w_b_zero;
  logic             w_any_ones;

  assign w_ea       = r_a[W-2:MAN_W];
  assign w_eb       = r_b[W-2:MAN_W];
  assign w_a_zero   = (w_ea == '0);
  assign w_b_zero   = (w_eb == '0);
  assign w_any_ones = (w_ea == C_E_ONES) | (w_eb == C_E_ONES);

  // One restoring-division step: subtract when the partial remainder covers the divisor
  logic             w_ge;
  logic [MAN_W+1:0] w_diff;
  logic [MAN_W+1:0] w_rem_next;

  assign w_ge       = (r_rem >= {1'b0, r_mb});
  assign w_diff     = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;
  assign w_rem_next = w_diff << 1;

  // Normalisation: quotient lies in [0.5, 2), so at most one left shift
  logic                 w_top;
  logic signed [SW-1:0] w_exp_n;
  logic [MAN_W-1:0]     w_man;
  logic signed [SW-1:0] w_exp_r;
  logic [MAN_W-1:0]     w_man_r;

  assign w_top   = r_q[QB-1];
  assign w_exp_n = w_top ? r_exp : (r_exp - SW'(1));
  assign w_man   = w_top ? r_q[QB-2:2] : r_q[QB-3:1];

`ifdef FP_DIV_ROUND_EN
  logic           w_guard;
  logic           w_sticky;
  logic           w_inc;
  logic [MAN_W:0] w_man_sum;

  assign w_guard   = w_top ? r_q[1] : r_q[0];
  assign w_sticky  = (r_rem != '0) | (w_top & r_q[0]);
  assign w_inc     = w_guard & (w_sticky | w_man[0]);
  assign w_man_sum = {1'b0, w_man} + {{MAN_W{1'b0}}, w_inc};
  assign w_man_r   = w_man_sum[MAN_W-1:0];
  // A carry out of the mantissa rolls into the exponent; overflow is checked on w_exp_r
  assign w_exp_r   = w_exp_n + SW'(w_man_sum[MAN_W]);
`else
  assign w_man_r   = w_man;
  assign w_exp_r   = w_exp_n;
`endif

  // Final result and flags with special cases taking priority over the computed quotient
  logic [W-1:0] w_res;
  logic         w_exc;
  logic         w_ovf;
  logic         w_unf;

  // Select the packed result and flag set to be registered in NORM
  always_comb begin
    w_exc = 1'b0;
    w_ovf = 1'b0;
    w_unf = 1'b0;
    w_res = {r_sign, w_exp_r[EXP_W-1:0], w_man_r};
    if (r_nan) begin
      w_exc = 1'b1;
      w_res = C_QNAN;
    end else if (r_inf_div) begin
      w_exc = 1'b1;
      w_res = {r_sign, C_E_ONES, {MAN_W{1'b0}}};
    end else if (r_zero) begin
      w_res = {r_sign, {(W-1){1'b0}}};
    end else if (w_exp_r >= C_EXP_MAX) begin
      w_ovf = 1'b1;
      w_res = {r_sign, C_E_ONES, {MAN_W{1'b0}}};
    end else if (w_exp_n <= C_EXP_ZERO) begin
      w_unf = 1'b1;
      w_res = {r_sign, {(W-1){1'b0}}};
    end
  end

  // Control FSM and datapath: IDLE -> UNPACK -> DIV (QB cycles) -> NORM -> IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_sign    <= 1'b0;
      r_exp     <= '0;
      r_mb      <= '0;
      r_rem     <= '0;
      r_q       <= '0;
      r_cnt     <= '0;
      r_nan     <= 1'b0;
      r_inf_div <= 1'b0;
      r_zero    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_exc     <= 1'b0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
      r_result  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a_operand;
            r_b     <= b_operand;
            r_busy  <= 1'b1;
            r_state <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          r_sign    <= r_a[W-1] ^ r_b[W-1];
          r_exp     <= SW'(w_ea) - SW'(w_eb) + C_BIAS;
          r_mb      <= {1'b1, r_b[MAN_W-1:0]};
          r_rem     <= {2'b01, r_a[MAN_W-1:0]};
          r_q       <= '0;
          r_cnt     <= '0;
          // Denormals count as zero; Inf/NaN or 0/0 give a quiet NaN
          r_nan     <= w_any_ones | (w_a_zero & w_b_zero);
          r_inf_div <= w_b_zero & ~w_a_zero;
          r_zero    <= w_a_zero;
          r_state   <= S_DIV;
        end
        S_DIV: begin
          r_rem <= w_rem_next;
          r_q   <= {r_q[QB-2:0], w_ge};
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(QB - 1)) begin
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          r_result <= w_res;
          r_exc    <= w_exc;
          r_ovf    <= w_ovf;
          r_unf    <= w_unf;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign Exception = r_exc;
  assign Overflow  = r_ovf;
  assign Underflow = r_unf;

endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: directed self-checking bench for fp_div_seq.
// Expected values are hand-computed; build with FP_DIV_ROUND_EN to check the rounding build.
`timescale 1ns/1ps
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a_operand = 32'h0;
  logic [31:0] b_operand = 32'h0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        Exception;
  logic        Overflow;
  logic        Underflow;

  int n_total = 0;
  int n_pass  = 0;

  fp_div_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a_operand (a_operand),
    .b_operand (b_operand),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .Exception (Exception),
    .Overflow  (Overflow),
    .Underflow (Underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp_v);
  endtask

  function automatic logic [31:0] flags();
    return {29'd0, Exception, Overflow, Underflow};
  endfunction

  // Present operands with start for one edge (edge 0); returns 1 ns after edge 0
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    a_operand = a;
    b_operand = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges after edge 0 until done; optionally pulse start again at edge inj_edge
  task automatic wait_done(input int inj_edge, input logic [31:0] ia, input logic [31:0] ib,
                           output int done_edge, output logic busy_at_inj);
    done_edge   = -1;
    busy_at_inj = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      if (e == inj_edge) begin
        @(negedge clk);
        a_operand = ia;
        b_operand = ib;
        start     = 1'b1;
      end
      @(posedge clk);
      #1;
      if (e == inj_edge) begin
        start       = 1'b0;
        busy_at_inj = busy;
      end
      if (done) begin
        done_edge = e;
        break;
      end
    end
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic [2:0] exp_flags);
    int   de;
    logic bi;
    launch(a, b);
    wait_done(0, 32'h0, 32'h0, de, bi);
    $display("op %s: %08h / %08h -> %08h flags(E,O,U)=%b%b%b done_edge=%0d",
             tag, a, b, result, Exception, Overflow, Underflow, de);
    check({tag, ".latency"}, 32'(de), 32'd28);
    check({tag, ".result"}, result, exp_res);
    check({tag, ".flags"}, flags(), {29'd0, exp_flags});
  endtask

  initial begin
    int          de;
    int          n_done;
    logic        bi;
    logic [31:0] busy_mask;
    logic [31:0] done_mask;
    logic [31:0] exp_q;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset.busy", {31'd0, busy}, 32'd0);
    check("reset.done", {31'd0, done}, 32'd0);
    check("reset.result", result, 32'h0);
    check("reset.flags", flags(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 6.0 / 2.0 with full busy/done timeline, bit k = value just after edge k
    busy_mask = '0;
    done_mask = '0;
    launch(32'h40C0_0000, 32'h4000_0000);
    busy_mask[0] = busy;
    done_mask[0] = done;
    for (int k = 1; k < 32; k++) begin
      @(posedge clk);
      #1;
      busy_mask[k] = busy;
      done_mask[k] = done;
    end
    $display("op t1: 40c00000 / 40000000 -> %08h busy_mask=%08h done_mask=%08h",
             result, busy_mask, done_mask);
    check("t1.busy_window", busy_mask, 32'h0FFF_FFFF);
    check("t1.done_pulse", done_mask, 32'h1000_0000);
    check("t1.result", result, 32'h4040_0000);
    check("t1.flags", flags(), 32'd0);

    // 1.0 / 3.0: repeating quotient exercises guard/sticky
`ifdef FP_DIV_ROUND_EN
    exp_q = 32'h3EAA_AAAB;
`else
    exp_q = 32'h3EAA_AAAA;
`endif
    do_op("t2.third", 32'h3F80_0000, 32'h4040_0000, exp_q, 3'b000);

    // Division by zero, then Inf operand
    do_op("t3.div0", 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 3'b100);
    do_op("t3.inf", 32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 3'b100);
    do_op("t3.zero_zero", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 3'b100);

    // Exponent range limits
    do_op("t4.ovf", 32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 3'b010);
    do_op("t4.unf", 32'h0080_0000, 32'h4F00_0000, 32'h0000_0000, 3'b001);

    // Signed zero dividend: -0 / 1.0 = -0, no flags
    do_op("t4.negzero", 32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 3'b000);

    // Second start while busy must be ignored
    launch(32'h40C0_0000, 32'h4000_0000);
    wait_done(5, 32'h3F80_0000, 32'h4040_0000, de, bi);
    $display("op t5: 40c00000 / 40000000 with start at edge 5 -> %08h done_edge=%0d", result, de);
    check("t5.busy_at_inj", {31'd0, bi}, 32'd1);
    check("t5.latency", 32'(de), 32'd28);
    check("t5.result", result, 32'h4040_0000);

    // Asynchronous reset in the middle of an operation
    launch(32'h3F80_0000, 32'h4040_0000);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    $display("op t6: reset at edge 10 -> busy=%b done=%b result=%08h", busy, done, result);
    check("t6.rst_busy", {31'd0, busy}, 32'd0);
    check("t6.rst_done", {31'd0, done}, 32'd0);
    check("t6.rst_result", result, 32'h0);
    check("t6.rst_flags", flags(), 32'd0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    check("t6.no_done_after_abort", 32'(n_done), 32'd0);
    do_op("t6.neg_div0", 32'hC152_6666, 32'h0000_0000, 32'hFF80_0000, 3'b100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time bound so the run can never hang
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
